// File: rtl/ring_buffer_pkg.sv
// Shared types and constants for the ring buffer reader and its skid store.
package ring_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } rb_state_e;

  localparam int RB_CNT_W = 16;

endpackage

// File: rtl/rb_skid2.sv
// Two-entry in-order skid store with synchronous clear.
// Entry 0 is always the oldest word and is presented on head_o.
module rb_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] head_o
);

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;

  // Next-state of entries and occupancy; push together with pop keeps occupancy.
  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (clear_i) begin
      occ_d = 2'd0;
      e0_d  = {WIDTH{1'b0}};
      e1_d  = {WIDTH{1'b0}};
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          case (occ_q)
            2'd0: begin
              e0_d  = data_i;
              occ_d = 2'd1;
            end
            2'd1: begin
              e1_d  = data_i;
              occ_d = 2'd2;
            end
            default: occ_d = occ_q;
          endcase
        end
        2'b01: begin
          if (occ_q != 2'd0) begin
            e0_d  = e1_q;
            occ_d = occ_q - 2'd1;
          end else begin
            occ_d = occ_q;
          end
        end
        2'b11: begin
          case (occ_q)
            2'd0: begin
              e0_d  = data_i;
              occ_d = 2'd1;
            end
            2'd1: e0_d = data_i;
            default: begin
              e0_d = e1_q;
              e1_d = data_i;
            end
          endcase
        end
        default: occ_d = occ_q;
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= 2'd0;
      e0_q  <= {WIDTH{1'b0}};
      e1_q  <= {WIDTH{1'b0}};
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = e0_q;

endmodule

// File: rtl/ring_buffer_reader.sv
// Drains an upstream ring buffer into a valid/ready stream through a 2-entry skid.
// Optional delivered-beat counter enabled by macro RB_READER_COUNT_EN.
module ring_buffer_reader
  import ring_buffer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                flush,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [WIDTH-1:0]    fifo_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic                busy_flush,
  output logic [RB_CNT_W-1:0] rd_count
);

  rb_state_e        state_q;
  logic             inflight_q;
  logic [1:0]       occ_s;
  logic [WIDTH-1:0] head_s;
  logic             xfer_s;
  logic             push_s;
  logic             clear_s;
  logic [2:0]       level_s;

  // The leaving beat frees its slot this cycle, which is what allows one beat per cycle.
  always_comb begin
    m_valid    = (occ_s != 2'd0) && (state_q != ST_FLUSH);
    xfer_s     = m_valid && m_ready;
    level_s    = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, xfer_s};
    push_s     = inflight_q && (state_q == ST_STREAM);
    clear_s    = (state_q == ST_FLUSH);
    busy_flush = (state_q == ST_FLUSH);
    case (state_q)
      ST_STREAM: fifo_rd_en = en && !fifo_empty && (level_s < 3'd2);
      ST_FLUSH:  fifo_rd_en = !fifo_empty;
      default:   fifo_rd_en = 1'b0;
    endcase
  end

  rb_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (xfer_s),
    .clear_i (clear_s),
    .data_i  (fifo_data),
    .occ_o   (occ_s),
    .head_o  (head_s)
  );

  assign m_data = head_s;

  // Control FSM and in-flight pop tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q <= ST_FLUSH;
          end else if (en) begin
            state_q <= ST_STREAM;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_STREAM: begin
          if (flush) begin
            state_q <= ST_FLUSH;
          end else if (!en && (occ_s == 2'd0) && !inflight_q) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_STREAM;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty && !inflight_q) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RB_READER_COUNT_EN
  logic [RB_CNT_W-1:0] count_q;

  // Delivered-beat counter; wraps naturally at full scale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {RB_CNT_W{1'b0}};
    end else if (xfer_s) begin
      count_q <= count_q + {{(RB_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign rd_count = count_q;
`else
  assign rd_count = {RB_CNT_W{1'b0}};
`endif

endmodule
